// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit: one bit per cycle, signed ops via magnitudes.
// Define MULT_DIV_UNIT_DIV_EN to build the restoring divider; otherwise divide ops finish at once with zeros.
//
// state | meaning
// IDLE  | waiting for start; operands captured on accept
// RUN   | 32 iterations of shift-add / shift-subtract
// DONE  | one-cycle completion pulse, hi/lo valid
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   work, work_nxt, prod_res;
  logic [WIDTH-1:0]     a_mag, b_mag, b_mag_r, hi_r, lo_r;
  logic [WIDTH:0]       add_sum;
  logic                 neg_q;

`ifdef MULT_DIV_UNIT_DIV_EN
  logic                 is_div, neg_r, dbz_r, ge;
  logic [WIDTH-1:0]     a_r, diff, quo_res, rem_res;
  logic [WIDTH:0]       part;
`endif

  assign a_mag = (op[0] && a[WIDTH-1]) ? -a : a;
  assign b_mag = (op[0] && b[WIDTH-1]) ? -b : b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef MULT_DIV_UNIT_DIV_EN
          state_nxt = RUN;
`else
          state_nxt = op[1] ? DONE : RUN;
`endif
        end
      end
      RUN:     if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Upper half accumulates the product / holds the remainder; lower half shifts the multiplier / quotient.
  always_comb begin
    add_sum  = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, b_mag_r} : '0);
    work_nxt = {add_sum, work[WIDTH-1:1]};
`ifdef MULT_DIV_UNIT_DIV_EN
    part = work[2*WIDTH-1:WIDTH-1];
    ge   = part >= {1'b0, b_mag_r};
    diff = part[WIDTH-1:0] - b_mag_r;
    if (is_div) work_nxt = ge ? {diff, work[WIDTH-2:0], 1'b1} : {work[2*WIDTH-2:0], 1'b0};
`endif
  end

  assign prod_res = neg_q ? -work_nxt : work_nxt;

`ifdef MULT_DIV_UNIT_DIV_EN
  assign quo_res = neg_q ? -work_nxt[WIDTH-1:0] : work_nxt[WIDTH-1:0];
  assign rem_res = neg_r ? -work_nxt[2*WIDTH-1:WIDTH] : work_nxt[2*WIDTH-1:WIDTH];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      work    <= '0;
      b_mag_r <= '0;
      neg_q   <= 1'b0;
      hi_r    <= '0;
      lo_r    <= '0;
`ifdef MULT_DIV_UNIT_DIV_EN
      is_div  <= 1'b0;
      neg_r   <= 1'b0;
      a_r     <= '0;
      dbz_r   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            work    <= {{WIDTH{1'b0}}, a_mag};
            b_mag_r <= b_mag;
            cnt     <= CW'(WIDTH - 1);
            neg_q   <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef MULT_DIV_UNIT_DIV_EN
            is_div  <= op[1];
            neg_r   <= op[0] & a[WIDTH-1];
            a_r     <= a;
`else
            if (op[1]) begin
              hi_r <= '0;
              lo_r <= '0;
            end
`endif
          end
        end
        RUN: begin
          work <= work_nxt;
          cnt  <= cnt - 1'b1;
          if (cnt == '0) begin
`ifdef MULT_DIV_UNIT_DIV_EN
            if (is_div) begin
              // Magnitude of zero only arises from a zero divisor.
              if (b_mag_r == '0) begin
                hi_r  <= a_r;
                lo_r  <= '1;
                dbz_r <= 1'b1;
              end else begin
                hi_r  <= rem_res;
                lo_r  <= quo_res;
                dbz_r <= 1'b0;
              end
            end else begin
              {hi_r, lo_r} <= prod_res;
              dbz_r        <= 1'b0;
            end
`else
            {hi_r, lo_r} <= prod_res;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign hi   = hi_r;
  assign lo   = lo_r;
`ifdef MULT_DIV_UNIT_DIV_EN
  assign div_by_zero = dbz_r & done;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table plus start-spam and mid-run reset sequences.
// Follows MULT_DIV_UNIT_DIV_EN to pick the divide expectations.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op_i;
  logic [31:0] a_i, b_i;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op_i), .a(a_i), .b(b_i),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Caller is away from the rising edge; start goes high now and is accepted on the next edge.
  task automatic run_check(input string nm, input vec_t v);
    int k;
    start = 1'b1; op_i = v.op; a_i = v.a; b_i = v.b;
    @(posedge clk); #1;
    start = 1'b0; a_i = $urandom; b_i = $urandom; op_i = v.op ^ 2'b01;
    if (v.lat > 1) chk({nm, " busy_run"}, 64'(busy), 64'd1);
    k = 0;
    while (!done && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk({nm, " latency"}, 64'(k + 1), 64'(v.lat));
    chk({nm, " hi"}, 64'(hi), 64'(v.hi));
    chk({nm, " lo"}, 64'(lo), 64'(v.lo));
    chk({nm, " dbz"}, 64'(div_by_zero), 64'(v.dbz));
    chk({nm, " busy_done"}, 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk({nm, " done_pulse"}, 64'(done), 64'd0);
    chk({nm, " dbz_low"}, 64'(div_by_zero), 64'd0);
  endtask

  initial begin
    int k, ndone;
    vec_t v;
    rst_n = 1'b0; start = 1'b0; op_i = 2'b00; a_i = '0; b_i = '0;

    vecs.push_back('{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33});
    vecs.push_back('{2'b01, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33});
    vecs.push_back('{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 33});
    vecs.push_back('{2'b01, 32'h8000_0000, 32'd2,         32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 33});
    vecs.push_back('{2'b00, 32'h1234_5678, 32'h10,        32'h0000_0001, 32'h2345_6780, 1'b0, 33});
    vecs.push_back('{2'b01, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, 1'b0, 33});
    vecs.push_back('{2'b00, 32'd0,         32'd1234,      32'h0000_0000, 32'h0000_0000, 1'b0, 33});
    vecs.push_back('{2'b00, 32'd6,         32'd7,         32'h0000_0000, 32'd42,        1'b0, 33});
`ifdef MULT_DIV_UNIT_DIV_EN
    vecs.push_back('{2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33});
    vecs.push_back('{2'b10, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1'b1, 33});
    vecs.push_back('{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 33});
    vecs.push_back('{2'b10, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 33});
    vecs.push_back('{2'b11, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0, 33});
    vecs.push_back('{2'b11, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 33});
    vecs.push_back('{2'b10, 32'hFFFF_FFFF, 32'd16,        32'd15,        32'h0FFF_FFFF, 1'b0, 33});
`else
    vecs.push_back('{2'b10, 32'd10,        32'd2,         32'd0,         32'd0,         1'b0, 1});
    vecs.push_back('{2'b00, 32'd9,         32'd9,         32'd0,         32'd81,        1'b0, 33});
    vecs.push_back('{2'b11, 32'hFFFF_FFF9, 32'd0,         32'd0,         32'd0,         1'b0, 1});
`endif

    repeat (3) @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    chk("reset dbz", 64'(div_by_zero), 64'd0);

    // Start on the very first edge after reset release.
    rst_n = 1'b1;
    v = '{2'b00, 32'd11, 32'd13, 32'd0, 32'd143, 1'b0, 33};
    run_check("first_edge", v);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      run_check($sformatf("vec%0d", i), vecs[i]);
    end

    // Start held high through the whole run with different operands.
    @(negedge clk);
    start = 1'b1; op_i = 2'b00; a_i = 32'd3; b_i = 32'd5;
    @(posedge clk); #1;
    op_i = 2'b01; a_i = 32'd100; b_i = 32'hFFFF_FF00;
    k = 0;
    while (!done && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    chk("spam latency", 64'(k + 1), 64'd33);
    chk("spam hi", 64'(hi), 64'd0);
    chk("spam lo", 64'(lo), 64'd15);
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("spam extra_done", 64'(ndone), 64'd0);

    // Reset pulse in the middle of a run.
    @(negedge clk);
    start = 1'b1; op_i = 2'b00; a_i = 32'hFFFF_FFFF; b_i = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("midrst busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst done", 64'(done), 64'd0);
    chk("midrst hi", 64'(hi), 64'd0);
    chk("midrst lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("midrst no_done", 64'(ndone), 64'd0);
    @(negedge clk);
    v = '{2'b00, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 33};
    run_check("after_rst", v);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  operation request, sampled only in IDLE.
REQ-005 SHALL have port op  input  2  00 multu, 01 mult, 10 divu, 11 div.
REQ-006 SHALL have port a  input  32  multiplicand / dividend, captured at start.
REQ-007 SHALL have port b  input  32  multiplier / divisor, captured at start.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port hi  output  32  product[63:32] or remainder.
REQ-011 SHALL have port lo  output  32  product[31:0] or quotient.
REQ-012 SHALL have port div_by_zero  output  1  asserted with done when a division had b=0.

Function
REQ-013 SHALL implement the FSM IDLE -> RUN -> DONE -> IDLE.
REQ-014 SHALL transition IDLE->RUN on the edge where start=1, capturing a, b and op; busy goes high in the following cycle.
REQ-015 SHALL remain in RUN for exactly 32 cycles, processing one bit per cycle: shift-add for multiply, restoring shift-subtract for divide.
REQ-016 SHALL spend one cycle in DONE, with done=1 and busy=0, so done is high at edge N+33 after start was accepted at edge N.
REQ-017 SHALL ignore start in RUN and DONE; no queueing.
REQ-018 SHALL update hi/lo only on entry to DONE and hold them until the next completion.
REQ-019 SHALL handle signed ops (01, 11) by iterating on magnitudes, then conditionally negating the results.
REQ-020 SHALL give the product sign as a[31]^b[31], the quotient sign as a[31]^b[31], and the remainder sign as a[31].
REQ-021 SHALL, for division with b=0: hi=a, lo=32'hFFFF_FFFF, div_by_zero=1 for the done cycle, with unchanged latency.
REQ-022 SHALL, for div of 0x8000_0000 by 0xFFFF_FFFF: lo=0x8000_0000, hi=0, div_by_zero=0.
REQ-023 SHALL keep div_by_zero=0 whenever done=0.
REQ-024 SHALL NOT let changes on a, b or op after capture affect the result in flight.

Reset
REQ-025 SHALL, on rst_n=0 and asynchronously, force IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0.
REQ-026 SHALL abandon any operation in flight when reset occurs, producing no done pulse after reset release.
REQ-027 SHALL accept start on the first clock edge after rst_n deasserts.

Configuration
REQ-028 SHALL compile in divide support when macro MULT_DIV_UNIT_DIV_EN is defined, giving the behaviour in REQ-015..REQ-023 for all ops.
REQ-029 SHALL, without MULT_DIV_UNIT_DIV_EN, include no divider datapath.
REQ-030 SHALL, without MULT_DIV_UNIT_DIV_EN, treat op 10/11 as follows: go IDLE->DONE directly, assert done one cycle after acceptance, set hi=lo=0 and div_by_zero=0.
REQ-031 SHALL leave multiply ops unaffected by MULT_DIV_UNIT_DIV_EN.

Verification
REQ-032 SHALL cover: multu a=0xFFFF_FFFF, b=0xFFFF_FFFF -> done at edge N+33, hi=0xFFFF_FFFE, lo=0x0000_0001.
REQ-033 SHALL cover: mult a=0xFFFF_FFFD (-3), b=7 -> hi=0xFFFF_FFFF, lo=0xFFFF_FFEB (-21).
REQ-034 SHALL cover, with DIV_EN: div a=-7, b=2 -> lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1); divu a=100, b=0 -> hi=100, lo=0xFFFF_FFFF, div_by_zero=1 for exactly one cycle.
REQ-035 SHALL cover: start re-asserted every cycle during RUN -> exactly one done pulse; result matches the first captured operands.
REQ-036 SHALL cover: rst_n pulsed low at RUN cycle 10 -> busy, done, hi, lo = 0 immediately; no done pulse follows; a new multu 3x5 then yields lo=15, hi=0.
REQ-037 SHALL cover, without DIV_EN: divu 10/2 -> done one cycle after start, hi=lo=0, div_by_zero=0.
